uart_rx_os16: RTL and testbench

- UART receive front-end. Converts the serial line into bytes and hands them to the image filter stage as a data byte plus a one-cycle done strobe.
- Uses 16x oversampling with a mid-bit sampling point, start-bit glitch rejection and a stop-bit check.
- Sits directly upstream of imfilter and drives its i_data/i_rx_done inputs.

---
 rtl/uart_rx_os16_if.sv | 10 +
 rtl/uart_rx_os16.sv | 103 ++++++++++
 tb/tb_uart_rx_os16.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: serial line in, received byte and status strobes out.
interface uart_rx_os16_if #(parameter int DATA_BITS = 8);
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_done;
    logic                 o_frame_err;
    logic                 o_busy;
    modport master (output i_rx, input o_data, o_rx_done, o_frame_err, o_busy);
    modport slave  (input i_rx, output o_data, o_rx_done, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: oversampled UART receiver with mid-bit sampling,
// start-bit glitch rejection and a stop-bit check.
module uart_rx_os16 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    uart_rx_os16_if.slave rx_if
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [SW-1:0]        samp_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q, data_q;
    logic                 done_q, ferr_q;
    logic                 rx_s, tick, half, full;

    assign rx_s   = sync_q[1];
    assign tick   = tick_q == TW'(TICK_DIV - 1);
    assign tick_d = tick ? '0 : tick_q + 1'b1;
    assign half   = tick && samp_q == SW'(OVERSAMPLE / 2 - 1);
    assign full   = tick && samp_q == SW'(OVERSAMPLE - 1);

    assign rx_if.o_data      = data_q;
    assign rx_if.o_rx_done   = done_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_busy      = state_q != IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_if.i_rx};
            tick_q <= tick_d;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            if (tick && state_q inside {START, DATA, STOP} && !(half && state_q == START) && !full)
                samp_q <= samp_q + 1'b1;
            case (state_q)
                IDLE: begin
                    // Start edge is caught on any clock so the sample phase is set by the edge.
                    if (!rx_s) begin
                        state_q <= START;
                        samp_q  <= '0;
                    end
                end
                START: begin
                    if (half) begin
                        state_q <= rx_s ? IDLE : DATA;
                        samp_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (full) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        samp_q  <= '0;
                        if (bit_q == BW'(DATA_BITS - 1))
                            state_q <= STOP;
                    end
                end
                STOP: begin
                    if (full) begin
                        if (rx_s) begin
                            data_q  <= shift_q;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line must not be read as a stream of new start bits.
                    if (rx_s)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: randomized frame stimulus against a byte/latency reference model.
module tb_uart_rx_os16;
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int OS       = 16;
    localparam int TICK     = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = TICK * OS;
    localparam int LAT      = BIT * 19 / 2;
    localparam int TOL      = TICK + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_os16_if #(.DATA_BITS(8)) bus();
    uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .rx_if(bus)
    );

    int checks = 0, errors = 0, cyc = 0, ferr_cnt = 0;
    bit prev_strobe = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic [7:0] got_d[$], exp_d[$];
    int got_c[$], exp_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_rx_done) begin
            got_d.push_back(bus.o_data);
            got_c.push_back(cyc);
        end
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_rx_done || bus.o_frame_err) begin
            checks++;
            if ((bus.o_rx_done && bus.o_frame_err) || prev_strobe) begin
                errors++;
                $display("FAIL strobe_shape: done=%b ferr=%b prev=%b, required single exclusive pulse",
                         bus.o_rx_done, bus.o_frame_err, prev_strobe);
            end
        end
        prev_strobe = bus.o_rx_done || bus.o_frame_err;
    end

    task automatic drive(input logic v, input int n);
        bus.i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bclk, input bit good);
        if (good) begin
            exp_d.push_back(b);
            exp_c.push_back(cyc);
            model_data = b;
        end
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(b[i], bclk);
        drive(good, bclk);
    endtask

    task automatic clear_queues();
        got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
        checks++; if (bus.o_rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_rx_done); end
        checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.o_frame_err); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        rst_n = 1'b1;
        repeat (5 * TICK) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_single();
        clear_queues();
        fork
            send_byte(8'hA5, BIT, 1'b1);
            begin
                repeat (5 * BIT) @(negedge clk);
                checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.o_busy); end
            end
        join
        drive(1'b1, BIT);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'($urandom), BIT, 1'b1);
            drive(1'b1, $urandom_range(1, BIT));
        end
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] - exp_c[i] < LAT - TOL || got_c[i] - exp_c[i] > LAT + TOL) begin
                errors++; $display("FAIL single_latency[%0d]: got %0d want %0d+-%0d", i, got_c[i] - exp_c[i], LAT, TOL);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        send_byte(8'h00, BIT, 1'b1);
        send_byte(8'hFF, BIT, 1'b1);
        send_byte(8'h3C, BIT, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), BIT, 1'b1);
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] - exp_c[i] < LAT - TOL || got_c[i] - exp_c[i] > LAT + TOL) begin
                errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d+-%0d", i, got_c[i] - exp_c[i], LAT, TOL);
            end
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        drive(1'b0, 3 * TICK);
        drive(1'b1, 2 * BIT);
        checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL glitch_done: got %0d want 0", got_d.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", bus.o_busy); end
        send_byte(8'h5A, BIT, 1'b1);
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== 1) begin errors++; $display("FAIL glitch_after_count: got %0d want 1", got_d.size()); end
        else begin
            checks++; if (got_d[0] !== exp_d[0]) begin errors++; $display("FAIL glitch_after_data: got %h want %h", got_d[0], exp_d[0]); end
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] prev;
        clear_queues();
        prev = model_data;
        send_byte(8'h81, BIT, 1'b0);
        drive(1'b0, 3 * BIT);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
        checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL ferr_done: got %0d want 0", got_d.size()); end
        checks++; if (bus.o_data !== prev) begin errors++; $display("FAIL ferr_data_hold: got %h want %h", bus.o_data, prev); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy: got %b want 1", bus.o_busy); end
        drive(1'b1, 2 * BIT);
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ferr_release_busy: got %b want 0", bus.o_busy); end
        checks++; if (ferr_cnt !== 1 || got_d.size() !== 0) begin
            errors++; $display("FAIL ferr_no_restart: ferr %0d done %0d want 1 and 0", ferr_cnt, got_d.size());
        end
        send_byte(8'h42, BIT, 1'b1);
        send_byte(8'($urandom), BIT, 1'b1);
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL ferr_after_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL ferr_after_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        clear_queues();
        b = 8'hC3;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(b[i], BIT);
        drive(b[4], BIT / 2);
        rst_n = 1'b0;
        bus.i_rx = 1'b1;
        model_data = 8'h00;
        #1;
        checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", bus.o_data); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_rx_done !== 1'b0 || bus.o_frame_err !== 1'b0) begin
            errors++; $display("FAIL midrst_strobes: done %b ferr %b want 0 0", bus.o_rx_done, bus.o_frame_err);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3 * BIT);
        checks++; if (got_d.size() !== 0 || ferr_cnt !== 0) begin
            errors++; $display("FAIL midrst_no_strobe: done %0d ferr %0d want 0 0", got_d.size(), ferr_cnt);
        end
        send_byte(8'h96, BIT, 1'b1);
        send_byte(8'($urandom), BIT, 1'b1);
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL midrst_after_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL midrst_after_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_baud_tol();
        clear_queues();
        send_byte(8'h55, BIT * 102 / 100, 1'b1);
        send_byte(8'($urandom), BIT * 102 / 100, 1'b1);
        drive(1'b1, BIT);
        send_byte(8'h55, BIT * 98 / 100, 1'b1);
        send_byte(8'($urandom), BIT * 98 / 100, 1'b1);
        drive(1'b1, BIT);
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL baud_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL baud_ferr: got %0d want 0", ferr_cnt); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL baud_data[%0d]: got %h want %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    initial begin
        bus.i_rx = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_baud_tol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
